// File: rtl/etc_emu_pkg.sv
// etc_emu_pkg: shared types and constants for the ETC vehicle emulator
package etc_emu_pkg;
  localparam int WIDTH_TIK_DEF = 16;
  localparam logic [1:0] EPASS_NONE = 2'b00;
  typedef enum logic [2:0] {IDLE, S1, G12, S2, G23, S3, FIN} emu_state_e;
  function automatic logic [31:0] min1(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction
endpackage

// File: rtl/etc_vehicle_emulator_timer.sv
// etc_phase_timer: loadable down-counter, expire high in the last cycle of the loaded count
module etc_phase_timer
  import etc_emu_pkg::*;
#(
  parameter int WIDTH_TIK = WIDTH_TIK_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [WIDTH_TIK-1:0] load_val,
  input  logic                 clear,
  output logic                 expire
);
  logic [WIDTH_TIK-1:0] cnt_q;
  assign expire = (cnt_q == WIDTH_TIK'(1));
  // clear beats load, load beats countdown; the counter parks at zero
  always_ff @(posedge clk) begin
    if (reset || clear) cnt_q <= '0;
    else if (load) cnt_q <= load_val;
    else if (cnt_q != '0) cnt_q <= cnt_q - WIDTH_TIK'(1);
  end
endmodule

// File: rtl/etc_vehicle_emulator.sv
// etc_vehicle_emulator: sensor1/2/3 + E-pass pulse-train generator; ETC_EMU_AUTOREPEAT_EN enables auto-repeat on held start
module etc_vehicle_emulator
  import etc_emu_pkg::*;
#(
  parameter int WIDTH_TIK = WIDTH_TIK_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [WIDTH_TIK-1:0] cfg_pulse,
  input  logic [WIDTH_TIK-1:0] cfg_gap12,
  input  logic [WIDTH_TIK-1:0] cfg_gap23,
  input  logic [1:0]           cfg_epass,
  output logic                 sensor1,
  output logic                 sensor2,
  output logic                 sensor3,
  output logic [1:0]           valid_Epass,
  output logic                 busy,
  output logic                 done
);
  emu_state_e state_q, state_d;
  logic [WIDTH_TIK-1:0] pulse_q, gap12_q, gap23_q, load_val;
  logic [1:0] epass_q;
  logic load, clear, expire;
  wire [WIDTH_TIK-1:0] p_in = WIDTH_TIK'(min1(32'(cfg_pulse)));
  wire [WIDTH_TIK-1:0] g12_in = WIDTH_TIK'(min1(32'(cfg_gap12)));
  wire [WIDTH_TIK-1:0] g23_in = WIDTH_TIK'(min1(32'(cfg_gap23)));
`ifdef ETC_EMU_AUTOREPEAT_EN
  logic rpt_q, rpt_d;
`endif

  etc_phase_timer #(.WIDTH_TIK(WIDTH_TIK)) u_timer (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .clear(clear), .expire(expire)
  );

  // next state and timer control; abort overrides everything, including a same-cycle expiry
  always_comb begin
    state_d = state_q;
    load = 1'b0;
    load_val = p_in;
    clear = 1'b0;
`ifdef ETC_EMU_AUTOREPEAT_EN
    rpt_d = rpt_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef ETC_EMU_AUTOREPEAT_EN
        if (start && (!rpt_q || expire)) begin
          state_d = S1;
          load = 1'b1;
          rpt_d = 1'b0;
        end else if (!start) rpt_d = 1'b0;
`else
        if (start) begin
          state_d = S1;
          load = 1'b1;
        end
`endif
      end
      S1: if (expire) begin
        state_d = G12;
        load = 1'b1;
        load_val = gap12_q;
      end
      G12: if (expire) begin
        state_d = S2;
        load = 1'b1;
        load_val = pulse_q;
      end
      S2: if (expire) begin
        state_d = G23;
        load = 1'b1;
        load_val = gap23_q;
      end
      G23: if (expire) begin
        state_d = S3;
        load = 1'b1;
        load_val = pulse_q;
      end
      S3: if (expire) state_d = FIN;
      FIN: begin
        state_d = IDLE;
`ifdef ETC_EMU_AUTOREPEAT_EN
        if (start) begin
          load = 1'b1;
          load_val = gap23_q;
          rpt_d = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      load = 1'b0;
      clear = 1'b1;
`ifdef ETC_EMU_AUTOREPEAT_EN
      rpt_d = 1'b0;
`endif
    end
  end

  // state, cfg latch on pass start, and outputs registered from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pulse_q <= '0;
      gap12_q <= '0;
      gap23_q <= '0;
      epass_q <= EPASS_NONE;
      sensor1 <= 1'b0;
      sensor2 <= 1'b0;
      sensor3 <= 1'b0;
      valid_Epass <= EPASS_NONE;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == S1) begin
        pulse_q <= p_in;
        gap12_q <= g12_in;
        gap23_q <= g23_in;
        epass_q <= cfg_epass;
      end
      sensor1 <= (state_d == S1);
      sensor2 <= (state_d == S2);
      sensor3 <= (state_d == S3);
      valid_Epass <= (state_d inside {S2, G23, S3, FIN}) ? epass_q : EPASS_NONE;
      busy <= (state_d != IDLE);
      done <= (state_d == FIN);
    end
  end

`ifdef ETC_EMU_AUTOREPEAT_EN
  // auto-repeat wait flag
  always_ff @(posedge clk) begin
    if (reset) rpt_q <= 1'b0;
    else rpt_q <= rpt_d;
  end
`endif
endmodule

// File: tb/tb_etc_vehicle_emulator.sv
// tb_etc_vehicle_emulator: directed and random checks against a cycle-index reference model
module tb_etc_vehicle_emulator;
  logic clk = 1'b0;
  logic reset, start, abort;
  logic [15:0] cfg_pulse, cfg_gap12, cfg_gap23;
  logic [1:0] cfg_epass;
  logic sensor1, sensor2, sensor3, busy, done;
  logic [1:0] valid_Epass;
  int checks = 0;
  int failures = 0;
  bit m_act = 0;
  int m_t, m_p, m_g12, m_g23;
  logic [1:0] m_e;

  etc_vehicle_emulator #(.WIDTH_TIK(16)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_pulse(cfg_pulse), .cfg_gap12(cfg_gap12), .cfg_gap23(cfg_gap23), .cfg_epass(cfg_epass),
    .sensor1(sensor1), .sensor2(sensor2), .sensor3(sensor3),
    .valid_Epass(valid_Epass), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic int fix(input logic [15:0] v);
    return (v == 0) ? 1 : int'(v);
  endfunction

  function automatic logic [6:0] expected();
    int a, b, c, d;
    a = m_p;
    b = m_p + m_g12;
    c = 2 * m_p + m_g12 + m_g23;
    d = 3 * m_p + m_g12 + m_g23;
    if (!m_act) return 7'd0;
    return {m_t >= 1 && m_t <= a, m_t > b && m_t <= b + m_p, m_t > c && m_t <= d,
            (m_t > b) ? m_e : 2'b00, 1'b1, m_t == d + 1};
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) m_act = 0;
    else if (m_act) begin
      if (abort || m_t == 3 * m_p + m_g12 + m_g23 + 1) m_act = 0;
      else m_t++;
    end else if (start && !abort) begin
      m_act = 1;
      m_t = 1;
      m_p = fix(cfg_pulse);
      m_g12 = fix(cfg_gap12);
      m_g23 = fix(cfg_gap23);
      m_e = cfg_epass;
    end
    @(negedge clk);
    checks++;
    assert ({sensor1, sensor2, sensor3, valid_Epass, busy, done} === expected()) else begin
      failures++;
      $error("FAIL outputs t=%0d obs=%b exp=%b", m_t,
             {sensor1, sensor2, sensor3, valid_Epass, busy, done}, expected());
    end
  endtask

  initial begin
    int f1, f2, f3, dc, dn, s1n;
    reset = 1; start = 0; abort = 0;
    cfg_pulse = 0; cfg_gap12 = 0; cfg_gap23 = 0; cfg_epass = 0;
    repeat (3) tick();
    reset = 0;
    repeat (50) tick();
    chk("idle_busy", busy, 0);
    // main pass with a stray start at cycle 20 and an epass change at cycle 30
    cfg_pulse = 15; cfg_gap12 = 100; cfg_gap23 = 150; cfg_epass = 2'b10; start = 1;
    tick();
    start = 0;
    f2 = 0; f3 = 0; dc = 0; dn = 0; s1n = 0;
    for (int k = 1; k <= 300; k++) begin
      if (sensor1) s1n++;
      if (sensor2 && f2 == 0) f2 = k;
      if (sensor3 && f3 == 0) f3 = k;
      if (done) begin dn++; dc = k; end
      if (k == 200) chk("main_epass_hold", valid_Epass, 2);
      start = (k == 20);
      if (k == 30) cfg_epass = 2'b01;
      tick();
    end
    chk("main_s1_len", s1n, 15);
    chk("main_s2_rise", f2, 116);
    chk("main_s3_rise", f3, 281);
    chk("main_done_cyc", dc, 296);
    chk("main_done_cnt", dn, 1);
    // zero counts become one-cycle phases
    cfg_pulse = 0; cfg_gap12 = 0; cfg_gap23 = 0; cfg_epass = 2'b11; start = 1;
    tick();
    start = 0;
    f1 = 0; f2 = 0; f3 = 0; dc = 0;
    for (int k = 1; k <= 8; k++) begin
      if (sensor1 && f1 == 0) f1 = k;
      if (sensor2 && f2 == 0) f2 = k;
      if (sensor3 && f3 == 0) f3 = k;
      if (done) dc = k;
      tick();
    end
    chk("zero_s1", f1, 1);
    chk("zero_s2", f2, 3);
    chk("zero_s3", f3, 5);
    chk("zero_done", dc, 6);
    // abort at cycle 50, fresh start at cycle 60
    cfg_pulse = 15; cfg_gap12 = 100; cfg_gap23 = 150; cfg_epass = 2'b10; start = 1;
    tick();
    start = 0;
    dn = 0;
    for (int k = 1; k <= 61; k++) begin
      if (done) dn++;
      if (k == 51) chk("abort_busy", busy, 0);
      if (k == 61) chk("restart_s1", sensor1, 1);
      abort = (k == 50);
      start = (k == 60);
      tick();
    end
    chk("abort_no_done", dn, 0);
    repeat (300) tick();
    // randomized traffic with short phases
    for (int i = 0; i < 4000; i++) begin
      cfg_pulse = 16'($urandom_range(0, 5));
      cfg_gap12 = 16'($urandom_range(0, 6));
      cfg_gap23 = 16'($urandom_range(0, 6));
      cfg_epass = 2'($urandom_range(0, 3));
      start = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 149) == 0);
      reset = ($urandom_range(0, 799) == 0);
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
